shared_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single 12-bit-address, 8-bit-data shared memory port among the GPU cores. Each core raises a level load or store request with address and store data and holds it until its `val_data` pulse. The arbiter serialises these requests onto one memory port, waits for the memory acknowledge (variable latency, bounded by a timeout) and routes the response back to the requesting core. It sits between the core array and the shared memory, in place of any direct core-to-memory wiring.

---
 rtl/gpu_pkg.sv | 13 +
 rtl/shared_mem_arbiter_if.sv | 24 ++
 rtl/shared_mem_arbiter_rr_pick.sv | 28 ++
 rtl/shared_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU core-array blocks: FSM encoding and bus defaults.
package gpu_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int CORE_ID_W  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Shared memory port: the arbiter is master, the memory is slave.
interface shared_mem_arbiter_if import gpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/shared_mem_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick import gpu_pkg::*; #(
  parameter int N_CORES = 16,
  parameter int ID_W    = CORE_ID_W
) (
  input  logic [N_CORES-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    index
);

  logic [ID_W-1:0] cand;

  // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_CORES);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising core load/store requests onto one shared memory port.
module shared_mem_arbiter import gpu_pkg::*; #(
  parameter int N_CORES = 16,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        core_req_ld,
  input  logic [N_CORES-1:0]        core_req_st,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_val_data,
  output logic [DATA_W-1:0]         core_rdata,
  shared_mem_arbiter_if.master      mem,
  output logic                      busy,
  output logic [CORE_ID_W-1:0]      grant_id,
  output logic                      err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]           state_q, state_d;
  logic [CORE_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_CORES-1:0]   skip_mask_q, skip_mask_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [CORE_ID_W-1:0] grant_id_q, grant_id_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_en_q, mem_en_d;
  logic [N_CORES-1:0]   val_q, val_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [N_CORES-1:0]   pick_req;
  logic                 pick_valid;
  logic [CORE_ID_W-1:0] pick_idx;
  logic [N_CORES-1:0]   grant_onehot;

  // The just-served core is masked for one IDLE cycle while its request drops.
  assign pick_req     = (core_req_ld | core_req_st) & ~skip_mask_q;
  assign grant_onehot = N_CORES'(1) << grant_id_q;

  rr_pick #(.N_CORES(N_CORES), .ID_W(CORE_ID_W)) u_rr_pick (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    skip_mask_d = skip_mask_q;
    cnt_d       = cnt_q;
    grant_id_d  = grant_id_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_en_d    = 1'b0;
    val_d       = '0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        skip_mask_d = '0;
        if (pick_valid) begin
          grant_id_d  = pick_idx;
          mem_addr_d  = core_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d = core_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          mem_we_d    = core_req_st[pick_idx];
          mem_en_d    = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem.mem_ack) begin
          rdata_d = mem_we_q ? '0 : mem.mem_rdata;
          val_d   = grant_onehot;
          state_d = ST_RESP;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_ack) begin
          rdata_d = mem_we_q ? '0 : mem.mem_rdata;
          val_d   = grant_onehot;
          state_d = ST_RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          rdata_d = '0;
          err_d   = 1'b1;
          val_d   = grant_onehot;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        rr_ptr_d    = CORE_ID_W'((int'(grant_id_q) + 1) % N_CORES);
        skip_mask_d = grant_onehot;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      skip_mask_q <= '0;
      cnt_q       <= '0;
      grant_id_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      val_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      skip_mask_q <= skip_mask_d;
      cnt_q       <= cnt_d;
      grant_id_q  <= grant_id_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_en_q    <= mem_en_d;
      val_q       <= val_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_en    = mem_en_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign core_val_data = val_q;
  assign core_rdata    = rdata_q;
  assign grant_id      = grant_id_q;
  assign err           = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: main instance plus a short-timeout instance.
module tb_shared_mem_arbiter;

  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_ld, req_st, req_ld_t, req_st_t;
  logic [N*AW-1:0] addr_v;
  logic [N*DW-1:0] wdata_v;
  logic [N-1:0]  val, val_t;
  logic [DW-1:0] rdata, rdata_t;
  logic          busy, busy_t, err, err_t;
  logic [3:0]    gid, gid_t;

  int checks = 0;
  int errors = 0;

  shared_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();
  shared_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_t ();

  shared_mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset), .core_req_ld(req_ld), .core_req_st(req_st),
    .core_addr(addr_v), .core_wdata(wdata_v), .core_val_data(val), .core_rdata(rdata),
    .mem(mem_if), .busy(busy), .grant_id(gid), .err(err)
  );

  shared_mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .reset(reset), .core_req_ld(req_ld_t), .core_req_st(req_st_t),
    .core_addr(addr_v), .core_wdata(wdata_v), .core_val_data(val_t), .core_rdata(rdata_t),
    .mem(mem_t), .busy(busy_t), .grant_id(gid_t), .err(err_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next ISSUE, check the grant, ack it at once and check the response.
  task automatic serve(input int exp_id, input string tag, output int n);
    n = 0;
    while (!mem_if.mem_en && n < 20) begin
      tick();
      n++;
    end
    check({tag, " grant"}, mem_if.mem_en ? 32'(gid) : 32'hFFFF, exp_id);
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 8'h11;
    tick();
    mem_if.mem_ack = 1'b0;
    check({tag, " val"}, val, 32'h1 << exp_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    reset = 1'b1;
    req_ld = '0; req_st = '0; req_ld_t = '0; req_st_t = '0;
    addr_v = '0; wdata_v = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    mem_t.mem_ack  = 1'b0; mem_t.mem_rdata  = '0;
    repeat (3) tick();

    check("rst val", val, 0);
    check("rst rdata", rdata, 0);
    check("rst mem_en/we", {mem_if.mem_en, mem_if.mem_we}, 0);
    check("rst addr/wdata", {mem_if.mem_addr, mem_if.mem_wdata}, 0);
    check("rst gid/err/busy", {gid, err, busy}, 0);
    reset = 1'b0;
    tick();

    // Fairness from rr_ptr 0: cores 0, 5, 15 held -> 0, 5, 15, then 0 after 5 drops.
    addr_v[0*AW +: AW] = 12'h010;
    addr_v[5*AW +: AW] = 12'h050;
    addr_v[15*AW +: AW] = 12'h0F0;
    req_ld[0] = 1'b1; req_ld[5] = 1'b1; req_ld[15] = 1'b1;
    serve(0, "fair0", n);
    serve(5, "fair5", n);
    check("b2b gap", n, 2);
    serve(15, "fair15", n);
    req_ld[5] = 1'b0;
    serve(0, "wrap0", n);
    req_ld = '0;
    tick();

    // Single load, ack in ISSUE.
    addr_v[3*AW +: AW] = 12'h123;
    req_ld[3] = 1'b1;
    tick();
    check("ld en/we", {mem_if.mem_en, mem_if.mem_we}, 2'b10);
    check("ld addr", mem_if.mem_addr, 12'h123);
    check("ld busy/gid", {busy, gid}, {1'b1, 4'd3});
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'hA5;
    tick();
    mem_if.mem_ack = 1'b0;
    req_ld[3] = 1'b0;
    check("ld val", val, 16'h0008);
    check("ld rdata", rdata, 8'hA5);
    check("ld en off", mem_if.mem_en, 0);
    tick();
    check("ld idle", {val, busy}, 0);

    // Store wins over load; response data forced to zero.
    addr_v[7*AW +: AW] = 12'h0FF;
    wdata_v[7*DW +: DW] = 8'h3C;
    req_ld[7] = 1'b1; req_st[7] = 1'b1;
    tick();
    check("st en/we", {mem_if.mem_en, mem_if.mem_we}, 2'b11);
    check("st wdata", mem_if.mem_wdata, 8'h3C);
    check("st addr", mem_if.mem_addr, 12'h0FF);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'h77;
    tick();
    mem_if.mem_ack = 1'b0;
    req_ld[7] = 1'b0; req_st[7] = 1'b0;
    check("st val", val, 16'h0080);
    check("st rdata", rdata, 0);
    tick();

    // Slow memory: ack 10 cycles after ISSUE.
    addr_v[9*AW +: AW] = 12'hABC;
    req_ld[9] = 1'b1;
    tick();
    check("slow issue", {mem_if.mem_en, gid}, {1'b1, 4'd9});
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_if.mem_en !== 1'b0 || mem_if.mem_addr !== 12'hABC || val !== '0 || busy !== 1'b1)
        bad++;
    end
    check("slow hold", bad, 0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'h5A;
    tick();
    mem_if.mem_ack = 1'b0;
    req_ld[9] = 1'b0;
    check("slow val", val, 16'h0200);
    check("slow rdata/err", {rdata, err}, {8'h5A, 1'b0});
    tick();

    // Timeout instance (TIMEOUT=4): no ack -> response 6 cycles after ISSUE.
    addr_v[2*AW +: AW] = 12'h044;
    req_ld_t[2] = 1'b1;
    tick();
    check("to issue", {mem_t.mem_en, gid_t}, {1'b1, 4'd2});
    n = 0;
    while (val_t == '0 && n < 20) begin
      tick();
      n++;
    end
    check("to latency", n, 6);
    check("to val", val_t, 16'h0004);
    check("to err/rdata", {err_t, rdata_t}, {1'b1, 8'h00});
    req_ld_t[2] = 1'b0;
    tick();
    check("to err pulse", err_t, 0);
    mem_t.mem_ack = 1'b1; mem_t.mem_rdata = 8'hEE;
    tick();
    mem_t.mem_ack = 1'b0;
    check("late ack ignored", {val_t, busy_t, mem_t.mem_en}, 0);
    req_ld_t[6] = 1'b1;
    tick();
    check("to next grant", {mem_t.mem_en, gid_t}, {1'b1, 4'd6});
    mem_t.mem_ack = 1'b1; mem_t.mem_rdata = 8'h42;
    tick();
    mem_t.mem_ack = 1'b0;
    req_ld_t[6] = 1'b0;
    check("to next val", {val_t, err_t, rdata_t}, {16'h0040, 1'b0, 8'h42});
    tick();

    // Reset while in WAIT: rr_ptr is 10, so core 11 wins before reset, core 2 after.
    req_ld[2] = 1'b1; req_ld[11] = 1'b1;
    tick();
    check("pre-rst grant", {mem_if.mem_en, gid}, {1'b1, 4'd11});
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst wait val/err", {val, err}, 0);
    check("rst wait bus", {mem_if.mem_en, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, 0);
    check("rst wait gid/busy/rdata", {gid, busy, rdata}, 0);
    reset = 1'b0;
    tick();
    check("post-rst grant", {mem_if.mem_en, gid}, {1'b1, 4'd2});
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 8'h99;
    tick();
    mem_if.mem_ack = 1'b0;
    req_ld = '0;
    check("post-rst val", val, 16'h0004);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
